// File: rtl/dfe_adapt_sslms.sv
// ---------------------------------------------------------------------------
// dfe_adapt_sslms
// Sign-sign LMS adaptation engine for the digital DFE feedback taps. Takes the
// equalised slice samples from the DFE, forms data decisions and error signs,
// and correlates them over a window of 2**Ndec clocks. At each window end,
// every tap accumulator steps by one LSB according to the sign of the
// window's vote. The upper Ncoef bits of each accumulator form the
// coefficient fed back to the DFE.
//
// Ports
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_en         adaptation enable
//   i_freeze     hold coefficients, pause adaptation
//   i_load_init  one-cycle pulse, load i_coef_init into the accumulators
//   i_coef_init  Ntap x Ncoef signed initial coefficients (tap 0 in LSBs)
//   i_dlev       unsigned target data level
//   i_dfe_out    Nti x Nadc signed DFE outputs (slice 0 in LSBs, oldest)
//   o_coef       Ntap x Ncoef signed coefficients (tap 0 in LSBs)
//   o_sat        per tap, accumulator sits at a saturation bound
//   o_upd        one-cycle pulse, coefficients were just updated
//   o_state      0 IDLE, 1 LOAD, 2 ADAPT, 3 FROZEN
// ---------------------------------------------------------------------------
module dfe_adapt_sslms #(
  parameter int Nadc  = 8,
  parameter int Ntap  = 1,
  parameter int Nti   = 1,
  parameter int Ncoef = 8,
  parameter int Nfrac = 6,
  parameter int Ndec  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_freeze,
  input  logic                    i_load_init,
  input  logic [Ntap*Ncoef-1:0]   i_coef_init,
  input  logic [Nadc-1:0]         i_dlev,
  input  logic [Nti*Nadc-1:0]     i_dfe_out,
  output logic [Ntap*Ncoef-1:0]   o_coef,
  output logic [Ntap-1:0]         o_sat,
  output logic                    o_upd,
  output logic [1:0]              o_state
);

  localparam int W  = Ncoef + Nfrac;
  localparam int VW = $clog2(Nti + 1) + Ndec + 2;
  localparam int EW = Nadc + 2;

  localparam logic signed [W-1:0]  ACC_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  ACC_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  ACC_ONE  = W'(1);
  localparam logic signed [VW-1:0] V_ONE    = VW'(1);
  localparam logic [Ndec-1:0]      WIN_LAST = {Ndec{1'b1}};
  localparam logic [Ndec-1:0]      WIN_ONE  = Ndec'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ADAPT  = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [Nti*Nadc-1:0]    r_x;
  // Decision history, oldest in bit 0; a stored 1 means +1, a 0 means -1.
  logic [Ntap-1:0]        r_hist;
  logic signed [W-1:0]    r_acc [Ntap];
  logic signed [VW-1:0]   r_vote [Ntap];
  logic [Ndec-1:0]        r_win;
  logic                   r_upd;

  logic [EW-1:0]          w_dl;
  logic [EW-1:0]          w_err [Nti];
  logic [Nti-1:0]         w_dpos;
  logic [Nti-1:0]         w_spos;
  logic [Ntap+Nti-1:0]    w_aug;
  logic signed [VW-1:0]   w_p [Ntap];
  logic signed [VW-1:0]   w_vnext [Ntap];
  logic signed [W-1:0]    w_acc_next [Ntap];
  logic                   w_load;
  logic                   w_accum;
  logic                   w_win_end;
  logic                   w_update;

  assign w_dl = {2'b00, i_dlev};

  // Per-slice decision (sign of sample) and error sign of x - d*dlev.
  always_comb begin
    w_dpos = '0;
    w_spos = '0;
    for (int k = 0; k < Nti; k++) begin
      w_dpos[k] = ~r_x[k*Nadc + Nadc - 1];
      w_err[k]  = {{2{r_x[k*Nadc + Nadc - 1]}}, r_x[k*Nadc +: Nadc]};
      if (w_dpos[k]) begin
        w_err[k] = w_err[k] - w_dl;
      end else begin
        w_err[k] = w_err[k] + w_dl;
      end
      w_spos[k] = ~w_err[k][EW-1];
    end
  end

  // Decisions in time order: previous-cycle history below this cycle's slices.
  assign w_aug = {w_dpos, r_hist};

  // Sign-sign correlation: slice k pairs its error with the decision i+1 UI back.
  always_comb begin
    for (int i = 0; i < Ntap; i++) begin
      w_p[i] = '0;
      for (int k = 0; k < Nti; k++) begin
        if (w_spos[k] == w_aug[Ntap + k - 1 - i]) begin
          w_p[i] = w_p[i] + V_ONE;
        end else begin
          w_p[i] = w_p[i] - V_ONE;
        end
      end
      w_vnext[i] = r_vote[i] + w_p[i];
    end
  end

  // Saturating one-LSB accumulator step from the sign of the full-window vote.
  always_comb begin
    for (int i = 0; i < Ntap; i++) begin
      w_acc_next[i] = r_acc[i];
      if (!w_vnext[i][VW-1] && (w_vnext[i] != '0) && (r_acc[i] != ACC_MAX)) begin
        w_acc_next[i] = r_acc[i] + ACC_ONE;
      end else if (w_vnext[i][VW-1] && (r_acc[i] != ACC_MIN)) begin
        w_acc_next[i] = r_acc[i] - ACC_ONE;
      end else begin
        w_acc_next[i] = r_acc[i];
      end
    end
  end

  assign w_win_end = (r_win == WIN_LAST);

  // Next-state logic; !en outranks freeze, and only an undisturbed ADAPT cycle accumulates.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    if (i_load_init) begin
      w_state_next = ST_LOAD;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = i_en ? ST_ADAPT : ST_IDLE;
        ST_LOAD:   w_state_next = i_en ? ST_ADAPT : ST_IDLE;
        ST_ADAPT: begin
          if (!i_en) begin
            w_state_next = ST_IDLE;
          end else if (i_freeze) begin
            w_state_next = ST_FROZEN;
          end else begin
            w_state_next = ST_ADAPT;
            w_accum      = 1'b1;
          end
        end
        ST_FROZEN: begin
          if (!i_en) begin
            w_state_next = ST_IDLE;
          end else if (!i_freeze) begin
            w_state_next = ST_ADAPT;
          end else begin
            w_state_next = ST_FROZEN;
          end
        end
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_update = w_accum & w_win_end;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Input register, decision history, votes, window counter and accumulators.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x    <= '0;
      r_hist <= '0;
      r_win  <= '0;
      r_upd  <= 1'b0;
      for (int i = 0; i < Ntap; i++) begin
        r_acc[i]  <= '0;
        r_vote[i] <= '0;
      end
    end else begin
      r_x    <= i_dfe_out;
      r_hist <= w_aug[Nti +: Ntap];
      r_upd  <= w_update;
      // Any cycle that does not accumulate throws away the partial window.
      if (w_accum && !w_win_end) begin
        r_win <= r_win + WIN_ONE;
      end else begin
        r_win <= '0;
      end
      for (int i = 0; i < Ntap; i++) begin
        if (w_load) begin
          r_acc[i] <= {i_coef_init[i*Ncoef +: Ncoef], {Nfrac{1'b0}}};
        end else if (w_update) begin
          r_acc[i] <= w_acc_next[i];
        end
        if (w_accum && !w_win_end) begin
          r_vote[i] <= w_vnext[i];
        end else begin
          r_vote[i] <= '0;
        end
      end
    end
  end

  // Coefficients are the accumulator MSBs; saturation flags track the bounds.
  always_comb begin
    o_coef = '0;
    o_sat  = '0;
    for (int i = 0; i < Ntap; i++) begin
      o_coef[i*Ncoef +: Ncoef] = r_acc[i][W-1 -: Ncoef];
      o_sat[i]                 = (r_acc[i] == ACC_MAX) || (r_acc[i] == ACC_MIN);
    end
  end

  assign o_upd   = r_upd;
  assign o_state = r_state;

endmodule

// File: tb/tb_dfe_adapt_sslms.sv
// ---------------------------------------------------------------------------
// tb_dfe_adapt_sslms
// Directed bench for dfe_adapt_sslms with Nadc=8, Ntap=2, Nti=4, Ncoef=6,
// Nfrac=4, Ndec=2, dlev=32. A behavioural model built on integers tracks the
// engine; each window end pushes the expected {sat, coef} onto a queue that
// is popped when the DUT pulses upd.
// ---------------------------------------------------------------------------
module tb_dfe_adapt_sslms;

  localparam int DLEV = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        freeze = 1'b0;
  logic        load_init = 1'b0;
  logic [11:0] coef_init = 12'h000;
  logic [7:0]  dlev = 8'd32;
  logic [31:0] dfe_out = 32'h0;
  logic [11:0] coef;
  logic [1:0]  sat;
  logic        upd;
  logic [1:0]  state;

  dfe_adapt_sslms #(
    .Nadc(8), .Ntap(2), .Nti(4), .Ncoef(6), .Nfrac(4), .Ndec(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_freeze(freeze),
    .i_load_init(load_init), .i_coef_init(coef_init), .i_dlev(dlev),
    .i_dfe_out(dfe_out), .o_coef(coef), .o_sat(sat), .o_upd(upd),
    .o_state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int upd_seen = 0;

  // Model state: what the DUT registers should hold.
  int mx[4];
  int mh[2];
  int mvote[2];
  int macc[2];
  int mwin;
  int mst;
  int m_upd;
  int drv[4];
  int cinit[2];
  logic [13:0] scb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] exp_pack();
    logic [5:0] c0;
    logic [5:0] c1;
    logic       s0;
    logic       s1;
    c0 = 6'(macc[0] >>> 4);
    c1 = 6'(macc[1] >>> 4);
    s0 = (macc[0] == 511) || (macc[0] == -512);
    s1 = (macc[1] == 511) || (macc[1] == -512);
    return {s1, s0, c1, c0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mx[k] = 0;
    for (int i = 0; i < 2; i++) begin
      mh[i] = -1;
      mvote[i] = 0;
      macc[i] = 0;
    end
    mwin = 0;
    mst = 0;
    m_upd = 0;
    scb_q.delete();
  endtask

  task automatic set_dfe(input int a0, input int a1, input int a2, input int a3);
    drv = '{a0, a1, a2, a3};
    dfe_out = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endtask

  task automatic set_init(input int c0, input int c1);
    cinit = '{c0, c1};
    coef_init = {6'(c1), 6'(c0)};
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int d[4];
    int s[4];
    int aug[6];
    int p[2];
    int vn;
    aug[0] = mh[0];
    aug[1] = mh[1];
    for (int k = 0; k < 4; k++) begin
      d[k] = (mx[k] < 0) ? -1 : 1;
      s[k] = (mx[k] - d[k] * DLEV >= 0) ? 1 : -1;
      aug[2 + k] = d[k];
    end
    for (int i = 0; i < 2; i++) begin
      p[i] = 0;
      for (int k = 0; k < 4; k++) p[i] += s[k] * aug[2 + k - 1 - i];
    end
    mh[0] = aug[4];
    mh[1] = aug[5];
    for (int k = 0; k < 4; k++) mx[k] = drv[k];
    m_upd = 0;
    if (load_init) begin
      mst = 1;
      for (int i = 0; i < 2; i++) begin
        macc[i] = cinit[i] * 16;
        mvote[i] = 0;
      end
      mwin = 0;
    end else if (mst == 2 && en && !freeze) begin
      for (int i = 0; i < 2; i++) begin
        vn = mvote[i] + p[i];
        if (mwin == 3) begin
          if (vn > 0 && macc[i] < 511) macc[i]++;
          else if (vn < 0 && macc[i] > -512) macc[i]--;
          mvote[i] = 0;
        end else begin
          mvote[i] = vn;
        end
      end
      if (mwin == 3) begin
        mwin = 0;
        m_upd = 1;
        scb_q.push_back(exp_pack());
      end else begin
        mwin++;
      end
    end else begin
      mvote[0] = 0;
      mvote[1] = 0;
      mwin = 0;
      case (mst)
        0, 1:    mst = en ? 2 : 0;
        2:       mst = en ? 3 : 0;
        3:       mst = !en ? 0 : (!freeze ? 2 : 3);
        default: mst = 0;
      endcase
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("state", state, mst);
    chk("upd", upd, m_upd);
    if (upd === 1'b1) begin
      upd_seen++;
      chk("scb_avail", 32'(scb_q.size() > 0), 32'd1);
      if (scb_q.size() > 0) chk("upd_coef_sat", {sat, coef}, scb_q.pop_front());
    end
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic run_to_win(input int w, input string tag);
    int guard;
    guard = 0;
    while (mwin != w && guard < 8) begin
      step();
      guard++;
    end
    chk(tag, 32'(mwin == w), 32'd1);
  endtask

  initial begin
    logic [13:0] snap;
    model_reset();
    set_dfe(40, 40, 40, 40);
    set_init(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_coef", coef, 12'h000);
    chk("rst_sat", sat, 2'b00);
    chk("rst_upd", upd, 1'b0);
    chk("rst_state", state, 2'd0);
    rst = 1'b0;
    steps(3);

    // Load with en low: one LOAD cycle, then IDLE.
    set_init(5, -3);
    load_init = 1'b1;
    step();
    chk("load_state", state, 2'd1);
    chk("load_coef", coef, 12'hF45);
    load_init = 1'b0;
    step();
    chk("load_idle", state, 2'd0);
    chk("load_coef_hold", coef, 12'hF45);
    chk("load_sat", sat, 2'b00);

    // Steady +40 from coef 0: 16 windows -> +1 on both taps.
    set_init(0, 0);
    en = 1'b1;
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    step();
    upd_seen = 0;
    steps(64);
    chk("win16_coef", coef, 12'h041);
    chk("win16_upd_cnt", upd_seen, 16);
    steps(128);
    chk("win48_coef", coef, 12'h0C3);

    // Asynchronous reset mid-window.
    steps(2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_coef", coef, 12'h000);
    chk("arst_state", state, 2'd0);
    chk("arst_upd", upd, 1'b0);
    chk("arst_sat", sat, 2'b00);
    model_reset();
    #1;
    rst = 1'b0;

    // Preload near the top, saturate at 511.
    en = 1'b0;
    steps(2);
    set_init(31, 31);
    en = 1'b1;
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    step();
    upd_seen = 0;
    steps(60);
    chk("sat_coef", coef, 12'h7DF);
    chk("sat_flags", sat, 2'b11);
    chk("sat_upd_cnt", upd_seen, 15);
    steps(12);
    chk("sat_coef_hold", coef, 12'h7DF);
    chk("sat_flags_hold", sat, 2'b11);
    chk("sat_upd_cnt2", upd_seen, 18);

    // Balanced errors give zero votes: no change, upd still pulses.
    set_dfe(40, 40, 24, 24);
    set_init(2, -2);
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    step();
    upd_seen = 0;
    steps(20);
    chk("zero_vote_coef", coef, 12'hF82);
    chk("zero_vote_upd_cnt", upd_seen, 5);

    // Freeze for three clocks at win_cnt = 2.
    set_dfe(40, 40, 40, 40);
    run_to_win(2, "reach_win2");
    snap = exp_pack();
    freeze = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("frz_state", state, 2'd3);
      chk("frz_coef", {sat, coef}, snap);
      chk("frz_upd", upd, 1'b0);
    end
    freeze = 1'b0;
    step();
    chk("rel_state", state, 2'd2);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("rel_upd", upd, 1'(j == 4));
    end

    // Freeze arriving on a window-end edge wins over the update.
    run_to_win(3, "reach_win3");
    freeze = 1'b1;
    step();
    chk("frz_end_upd", upd, 1'b0);
    chk("frz_end_state", state, 2'd3);
    freeze = 1'b0;
    step();

    // Dropping en mid-window discards the partial window.
    run_to_win(1, "reach_win1");
    en = 1'b0;
    step();
    chk("en_drop_state", state, 2'd0);
    en = 1'b1;
    steps(6);

    // Random samples with occasional freeze.
    set_init(0, 0);
    load_init = 1'b1;
    step();
    load_init = 1'b0;
    for (int j = 0; j < 160; j++) begin
      set_dfe(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      freeze = ($urandom_range(0, 15) == 0);
      step();
    end
    freeze = 1'b0;
    steps(8);
    chk("scb_drained", scb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
